pulse_channel: RTL and testbench
================================

# pulse_channel

Parametrised square-wave tone channel with duty-cycle sequencer and period sweep, the successor to the single-mode frequency generator in the audio path. A down-counting timer clocks an 8-step duty sequencer. A sweep unit, paced by an external sweep clock and a programmable divider, raises or lowers the period. The channel mutes itself on illegal periods, and its output feeds the mixer.

## Interface
- PERIOD_W, 11, width of period, timer and target arithmetic
- SHIFT_W, 3, width of sweep shift amount
- DIV_W, 3, width of sweep divider reload value
- MIN_PERIOD, 8, periods below this mute the channel
- clk  in  1  system clock; sole clock domain
- iReset_n  in  1  asynchronous, active-low reset
- iPeriod_load  in  1  one-cycle strobe: load iPeriod
- iPeriod  in  PERIOD_W  base period value
- iDuty  in  2  duty select: 0=12.5%, 1=25%, 2=50%, 3=75%
- iSweep_clk  in  1  asynchronous sweep clock (level)
- iSweep_enable  in  1  allow sweep to write period
- iSweep_negate  in  1  0: period grows (pitch down); 1: period shrinks
- iSweep_shift  in  SHIFT_W  delta = cur_period >> shift; 0 = no update
- iSweep_divider  in  DIV_W  sweep updates every (divider+1) sweep edges
- oData  out  1  tone output
- oMute  out  1  channel silenced
- oPeriod  out  PERIOD_W  current (possibly swept) period

## Operation
- Reset (async, iReset_n=0):
  - cur_period=0, timer=0, step=0, divider counter=0, sync flops=0.
  - Outputs: oPeriod=0, oMute=1, oData=0.
- Timer:
  - Nonzero: decrement each clk.
  - At 0: reload cur_period and advance step (3-bit, 7 wraps to 0).
- Duty patterns, bit indexed by step:
  - 0: 00000001.
  - 1: 00000011.
  - 2: 00001111.
  - 3: 11111100.
  - iDuty changes take effect at the next step.
- Output gating:
  - The sequencer bit is registered.
  - oData = seq_bit & ~oMute (combinational AND).
- Sweep target:
  - Computed at PERIOD_W+1 bits: target = cur_period ± (cur_period >> iSweep_shift).
  - With negate=1 the target cannot underflow.
- oMute (combinational) = (cur_period < MIN_PERIOD) | (!negate & target[PERIOD_W]).
  - Mute evaluates regardless of iSweep_enable.
- Sweep edge: iSweep_clk passes a 2-flop synchroniser, then a rising-edge detect. On each detected edge:
  - If divider counter==0: reload it with iSweep_divider. If iSweep_enable & shift≠0 & !oMute, cur_period <= target[PERIOD_W-1:0].
  - Otherwise: decrement the divider counter.
- iPeriod_load:
  - Sets cur_period=iPeriod, timer=iPeriod, step=0 and divider counter=iSweep_divider.
  - Has priority over a sweep update in the same cycle; that sweep edge is consumed and discarded.
- The timer reload and the sweep write in the same cycle: the timer reloads the old cur_period, and the new value applies from the next reload.

## Timing
- Step period = cur_period+1 clks; full waveform = 8*(cur_period+1) clks.
- iSweep_clk rise to cur_period update: 3 clk edges (sync, sync, detect register), given setup is met.
- iPeriod_load seen at edge n: cur_period and timer are valid after edge n, and oPeriod shows the new value in the same cycle.
- oMute and oData follow cur_period combinationally, with no extra latency.
- Reset mid-operation: all state clears immediately; the first waveform needs iPeriod_load.

## Structure
- Shared package apu_pkg holds:
  - the duty pattern constant array (4×8 bits);
  - the MIN_PERIOD default;
  - the duty encoding enum (DUTY_12, DUTY_25, DUTY_50, DUTY_75).
- Sub-module sweep_unit contains the synchroniser, edge detect, divider counter, target adder and mute logic. It outputs sweep_write, target and mute.
- Timer and sequencer live in the top.

## Test plan
- Reset, then load iPeriod=10, iDuty=2 → oData high for 4*11=44 clks, low 44 clks, repeating; oMute=0.
- Load iPeriod=5 → oMute=1 and oData=0 constantly; load 8 → tone resumes.
- Sweep up: iPeriod=100, shift=1, divider=0, enable, negate=0, one iSweep_clk pulse → oPeriod=150 three clks after the rise.
- Overflow mute: iPeriod=1500, shift=1, negate=0, enable → oMute=1 (target 2250 > 2047); sweep pulses leave oPeriod=1500.
- Sweep down with divider=2: iPeriod=256, shift=2, negate=1, six sweep pulses → oPeriod 192 after the 3rd pulse and 144 after the 6th.
- iPeriod_load in the same cycle as a detected sweep edge → oPeriod=iPeriod and the sweep update is dropped; iReset_n low mid-tone → outputs 0/1/0 immediately.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared definitions for the audio tone channels: duty encoding, duty waveforms
// and the default lowest audible period.
package apu_pkg;

    localparam int MIN_PERIOD_DEFAULT = 8;

    typedef enum logic [1:0] {
        DUTY_12 = 2'd0,
        DUTY_25 = 2'd1,
        DUTY_50 = 2'd2,
        DUTY_75 = 2'd3
    } duty_e;

    // Row selected by duty code, bit selected by sequencer step.
    localparam logic [3:0][7:0] DUTY_PATTERN = {
        8'b1111_1100,
        8'b0000_1111,
        8'b0000_0011,
        8'b0000_0001
    };

    function automatic logic dutyBit(input logic [1:0] duty, input logic [2:0] step);
        return DUTY_PATTERN[duty][step];
    endfunction

endpackage

// File: rtl/sweep_unit.sv
// Period sweep: synchronises the external sweep clock, paces updates through a
// reload divider, and flags periods that must silence the channel.
module sweep_unit
    import apu_pkg::*;
#(
    parameter int PERIOD_W   = 11,
    parameter int SHIFT_W    = 3,
    parameter int DIV_W      = 3,
    parameter int MIN_PERIOD = MIN_PERIOD_DEFAULT
) (
    input  logic                clk,
    input  logic                iReset_n,
    input  logic                iSweep_clk,
    input  logic                iSweep_enable,
    input  logic                iSweep_negate,
    input  logic [SHIFT_W-1:0]  iSweep_shift,
    input  logic [DIV_W-1:0]    iSweep_divider,
    input  logic                iPeriod_load,
    input  logic [PERIOD_W-1:0] curPeriod,
    output logic                sweep_write,
    output logic [PERIOD_W-1:0] target,
    output logic                mute
);

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

    logic             syncA;
    logic             syncB;
    logic             syncPrev;
    logic             sweepEdge;
    logic [DIV_W-1:0] divCnt;
    logic [PERIOD_W:0] delta;
    logic [PERIOD_W:0] fullTarget;

    assign sweepEdge = syncB & ~syncPrev;

    // Extra bit catches overflow when growing; shrinking never borrows.
    assign delta      = {1'b0, curPeriod >> iSweep_shift};
    assign fullTarget = iSweep_negate ? ({1'b0, curPeriod} - delta)
                                      : ({1'b0, curPeriod} + delta);
    assign target     = fullTarget[PERIOD_W-1:0];

    assign mute = (curPeriod < MIN_P) | (~iSweep_negate & fullTarget[PERIOD_W]);

    assign sweep_write = sweepEdge & ~iPeriod_load & (divCnt == '0) & iSweep_enable
                       & (iSweep_shift != '0) & ~mute;

    always_ff @(posedge clk or negedge iReset_n) begin
        if (!iReset_n) begin
            syncA    <= 1'b0;
            syncB    <= 1'b0;
            syncPrev <= 1'b0;
            divCnt   <= '0;
        end else begin
            syncA    <= iSweep_clk;
            syncB    <= syncA;
            syncPrev <= syncB;
            if (iPeriod_load) begin
                divCnt <= iSweep_divider;
            end else if (sweepEdge) begin
                if (divCnt == '0) begin
                    divCnt <= iSweep_divider;
                end else begin
                    divCnt <= divCnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pulse_channel.sv
// Square-wave tone channel: down-counting step timer driving an 8-step duty
// sequencer, with period sweep and self-muting on illegal periods.
module pulse_channel
    import apu_pkg::*;
#(
    parameter int PERIOD_W   = 11,
    parameter int SHIFT_W    = 3,
    parameter int DIV_W      = 3,
    parameter int MIN_PERIOD = MIN_PERIOD_DEFAULT
) (
    input  logic                clk,
    input  logic                iReset_n,
    input  logic                iPeriod_load,
    input  logic [PERIOD_W-1:0] iPeriod,
    input  logic [1:0]          iDuty,
    input  logic                iSweep_clk,
    input  logic                iSweep_enable,
    input  logic                iSweep_negate,
    input  logic [SHIFT_W-1:0]  iSweep_shift,
    input  logic [DIV_W-1:0]    iSweep_divider,
    output logic                oData,
    output logic                oMute,
    output logic [PERIOD_W-1:0] oPeriod
);

    logic [PERIOD_W-1:0] curPeriod;
    logic [PERIOD_W-1:0] timer;
    logic [2:0]          step;
    logic [2:0]          nextStep;
    logic                seqBit;
    logic                sweepWrite;
    logic [PERIOD_W-1:0] target;
    logic                mute;

    sweep_unit #(
        .PERIOD_W   (PERIOD_W),
        .SHIFT_W    (SHIFT_W),
        .DIV_W      (DIV_W),
        .MIN_PERIOD (MIN_PERIOD)
    ) uSweep (
        .clk            (clk),
        .iReset_n       (iReset_n),
        .iSweep_clk     (iSweep_clk),
        .iSweep_enable  (iSweep_enable),
        .iSweep_negate  (iSweep_negate),
        .iSweep_shift   (iSweep_shift),
        .iSweep_divider (iSweep_divider),
        .iPeriod_load   (iPeriod_load),
        .curPeriod      (curPeriod),
        .sweep_write    (sweepWrite),
        .target         (target),
        .mute           (mute)
    );

    assign nextStep = step + 3'd1;

    // A reload in the same cycle as a sweep write uses the pre-sweep period.
    always_ff @(posedge clk or negedge iReset_n) begin
        if (!iReset_n) begin
            curPeriod <= '0;
            timer     <= '0;
            step      <= '0;
            seqBit    <= 1'b0;
        end else if (iPeriod_load) begin
            curPeriod <= iPeriod;
            timer     <= iPeriod;
            step      <= '0;
            seqBit    <= dutyBit(iDuty, 3'd0);
        end else begin
            if (sweepWrite) begin
                curPeriod <= target;
            end
            if (timer == '0) begin
                timer  <= curPeriod;
                step   <= nextStep;
                seqBit <= dutyBit(iDuty, nextStep);
            end else begin
                timer <= timer - 1'b1;
            end
        end
    end

    assign oMute   = mute;
    assign oData   = seqBit & ~mute;
    assign oPeriod = curPeriod;

endmodule

// File: tb/tb_pulse_channel.sv
// Bench for pulse_channel: directed checks with hand-computed values plus
// randomized traffic compared each cycle against a behavioural model.
module tb_pulse_channel;

    logic        clk = 1'b0;
    logic        iReset_n = 1'b0;
    logic        iPeriod_load = 1'b0;
    logic [10:0] iPeriod = '0;
    logic [1:0]  iDuty = '0;
    logic        iSweep_clk = 1'b0;
    logic        iSweep_enable = 1'b0;
    logic        iSweep_negate = 1'b0;
    logic [2:0]  iSweep_shift = '0;
    logic [2:0]  iSweep_divider = '0;
    logic        oData;
    logic        oMute;
    logic [10:0] oPeriod;

    int errors = 0;
    int checks = 0;
    bit running = 0;

    pulse_channel dut (
        .clk            (clk),
        .iReset_n       (iReset_n),
        .iPeriod_load   (iPeriod_load),
        .iPeriod        (iPeriod),
        .iDuty          (iDuty),
        .iSweep_clk     (iSweep_clk),
        .iSweep_enable  (iSweep_enable),
        .iSweep_negate  (iSweep_negate),
        .iSweep_shift   (iSweep_shift),
        .iSweep_divider (iSweep_divider),
        .oData          (oData),
        .oMute          (oMute),
        .oPeriod        (oPeriod)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit dutyHigh(input int duty, input int step);
        case (duty)
            0:       return step == 0;
            1:       return step < 2;
            2:       return step < 4;
            default: return step >= 2;
        endcase
    endfunction

    function automatic int sweepTarget(input int p, input bit neg, input int sh);
        return neg ? p - (p >> sh) : p + (p >> sh);
    endfunction

    function automatic bit modelMute(input int p, input bit neg, input int sh);
        return (p < 8) || (!neg && sweepTarget(p, neg, sh) > 2047);
    endfunction

    int mPeriod = 0;     // current period
    int mStep = 0;       // waveform step 0..7
    int mElapsed = 0;    // clocks spent in the current step
    int mStepLen = 1;    // length of the current step in clocks
    bit mBit = 0;        // duty level of the current step
    int mEdgeCnt = 0;    // sweep edges seen since the divider last fired
    int mDivLoaded = 0;  // divider value in force
    bit [2:0] sHist = '0; // sweep clock samples from the last three edges

    always @(posedge clk or negedge iReset_n) begin
        if (!iReset_n) begin
            mPeriod = 0; mStep = 0; mElapsed = 0; mStepLen = 1; mBit = 0;
            mEdgeCnt = 0; mDivLoaded = 0; sHist = '0;
        end else begin
            // A rise sampled two edges ago is acted on now.
            bit sweepEdge;
            int newP;
            sweepEdge = sHist[1] && !sHist[2];
            if (iPeriod_load) begin
                mPeriod = int'(iPeriod);
                mStep = 0; mElapsed = 0; mStepLen = int'(iPeriod) + 1;
                mBit = dutyHigh(int'(iDuty), 0);
                mEdgeCnt = 0; mDivLoaded = int'(iSweep_divider);
            end else begin
                newP = mPeriod;
                if (sweepEdge) begin
                    if (mEdgeCnt == mDivLoaded) begin
                        mEdgeCnt = 0;
                        mDivLoaded = int'(iSweep_divider);
                        if (iSweep_enable && iSweep_shift != 0 &&
                            !modelMute(mPeriod, iSweep_negate, int'(iSweep_shift)))
                            newP = sweepTarget(mPeriod, iSweep_negate, int'(iSweep_shift));
                    end else begin
                        mEdgeCnt++;
                    end
                end
                if (mElapsed == mStepLen - 1) begin
                    mStep = (mStep + 1) % 8;
                    mStepLen = mPeriod + 1;
                    mBit = dutyHigh(int'(iDuty), mStep);
                    mElapsed = 0;
                end else begin
                    mElapsed++;
                end
                mPeriod = newP;
            end
            sHist = {sHist[1:0], iSweep_clk};
        end
    end

    always @(negedge clk) begin
        if (running) begin
            bit em;
            em = modelMute(mPeriod, iSweep_negate, int'(iSweep_shift));
            check("model_period", int'(oPeriod), mPeriod);
            check("model_mute", int'(oMute), int'(em));
            check("model_data", int'(oData), int'(mBit && !em));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tickN(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic loadPeriod(input int p);
        iPeriod = 11'(p);
        iPeriod_load = 1'b1;
        tickN(1);
        iPeriod_load = 1'b0;
    endtask

    task automatic sweepPulse();
        iSweep_clk = 1'b1;
        tickN(4);
        iSweep_clk = 1'b0;
        tickN(4);
    endtask

    initial begin
        int hi;
        int lo;
        iReset_n = 1'b0;
        @(posedge clk);
        running = 1;
        tickN(2);
        @(negedge clk);
        check("reset_period", int'(oPeriod), 0);
        check("reset_mute", int'(oMute), 1);
        check("reset_data", int'(oData), 0);
        tickN(1);
        iReset_n = 1'b1;
        tickN(2);

        // 50% duty at period 10: 44 clocks high, 44 low
        iDuty = 2'd2;
        loadPeriod(10);
        for (int rep = 0; rep < 2; rep++) begin
            hi = 0;
            lo = 0;
            for (int i = 0; i < 88; i++) begin
                @(negedge clk);
                if (i < 44 && oData) hi++;
                if (i >= 44 && !oData) lo++;
            end
            check("duty50_high_run", hi, 44);
            check("duty50_low_run", lo, 44);
        end
        check("duty50_mute", int'(oMute), 0);
        tickN(1);

        // Illegal period mutes, boundary period 8 plays
        loadPeriod(5);
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (oData) hi++;
        end
        check("p5_mute", int'(oMute), 1);
        check("p5_data_high_count", hi, 0);
        tickN(1);
        loadPeriod(8);
        @(negedge clk);
        check("p8_mute", int'(oMute), 0);
        check("p8_data", int'(oData), 1);
        tickN(1);

        // Sweep up 100 -> 150, three edges after the rise
        iSweep_shift = 3'd1; iSweep_divider = 3'd0; iSweep_enable = 1'b1; iSweep_negate = 1'b0;
        loadPeriod(100);
        tickN(2);
        iSweep_clk = 1'b1;
        tickN(2);
        @(negedge clk);
        check("sweep_up_before", int'(oPeriod), 100);
        tickN(1);
        @(negedge clk);
        check("sweep_up_after", int'(oPeriod), 150);
        tickN(1);
        iSweep_clk = 1'b0;
        tickN(4);

        // Growing past 2047 mutes and blocks the sweep
        loadPeriod(1500);
        @(negedge clk);
        check("overflow_mute", int'(oMute), 1);
        tickN(1);
        repeat (3) sweepPulse();
        check("overflow_period", int'(oPeriod), 1500);

        // Shrinking sweep, divider 2
        iSweep_shift = 3'd2; iSweep_negate = 1'b1; iSweep_divider = 3'd2;
        loadPeriod(256);
        repeat (2) sweepPulse();
        check("sweep_down_2nd", int'(oPeriod), 256);
        sweepPulse();
        check("sweep_down_3rd", int'(oPeriod), 192);
        repeat (3) sweepPulse();
        check("sweep_down_6th", int'(oPeriod), 144);

        // Load in the same cycle as a detected sweep edge
        iSweep_shift = 3'd1; iSweep_negate = 1'b0; iSweep_divider = 3'd0;
        loadPeriod(200);
        tickN(2);
        iSweep_clk = 1'b1;
        tickN(2);
        iPeriod = 11'd77;
        iPeriod_load = 1'b1;
        tickN(1);
        iPeriod_load = 1'b0;
        @(negedge clk);
        check("load_vs_sweep", int'(oPeriod), 77);
        tickN(3);
        iSweep_clk = 1'b0;
        tickN(4);
        check("load_vs_sweep_hold", int'(oPeriod), 77);
        sweepPulse();
        check("sweep_after_drop", int'(oPeriod), 115);

        // Reset in the middle of a tone
        iSweep_enable = 1'b0;
        iDuty = 2'd2;
        loadPeriod(10);
        tickN(5);
        check("pre_reset_data", int'(oData), 1);
        iReset_n = 1'b0;
        #1;
        check("midreset_data", int'(oData), 0);
        check("midreset_mute", int'(oMute), 1);
        check("midreset_period", int'(oPeriod), 0);
        tickN(3);
        iReset_n = 1'b1;
        tickN(2);

        // Randomized traffic against the model
        for (int seg = 0; seg < 20; seg++) begin
            int p;
            case ($urandom_range(0, 3))
                0:       p = $urandom_range(0, 7);
                1:       p = $urandom_range(8, 40);
                2:       p = $urandom_range(41, 2047);
                default: p = $urandom_range(1200, 2047);
            endcase
            iDuty = 2'($urandom_range(0, 3));
            iSweep_enable = 1'($urandom_range(0, 1));
            iSweep_negate = 1'($urandom_range(0, 1));
            iSweep_shift = 3'($urandom_range(0, 7));
            iSweep_divider = 3'($urandom_range(0, 7));
            loadPeriod(p);
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 3) == 0) iSweep_clk = ~iSweep_clk;
                if ($urandom_range(0, 15) == 0) iDuty = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 31) == 0) begin
                    iSweep_enable = 1'($urandom_range(0, 1));
                    iSweep_negate = 1'($urandom_range(0, 1));
                    iSweep_shift = 3'($urandom_range(0, 7));
                end
                if ($urandom_range(0, 99) == 0) begin
                    iPeriod = 11'($urandom_range(0, 2047));
                    iPeriod_load = 1'b1;
                end
                tickN(1);
                iPeriod_load = 1'b0;
            end
        end

        running = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
